// File: rtl/prog_lut_pkg.sv
// Shared types and sizing helpers for the programmable truth-table evaluator.
package prog_lut_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam int MAX_N_IN = 6;

  function automatic int tbl_bits(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction

  // Counter must be able to represent the full table length without wrapping.
  function automatic int cnt_bits(input int tbl);
    return $clog2(tbl + 1);
  endfunction

endpackage

// File: rtl/prog_lut_if.sv
// Evaluation and serial-configuration signal bundle for prog_lut.
interface prog_lut_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
) ();

  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic [N_OUT-1:0] out_vec;
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_data;
  logic             cfg_done;
  logic             busy;

  modport master (
    output in_valid, in_vec, cfg_start, cfg_valid, cfg_data,
    input  out_valid, out_vec, cfg_done, busy
  );

  modport slave (
    input  in_valid, in_vec, cfg_start, cfg_valid, cfg_data,
    output out_valid, out_vec, cfg_done, busy
  );

endinterface

// File: rtl/prog_lut_cfg.sv
// Serial table loader: shadow shift register, bit counter and RUN/LOAD control.
module prog_lut_cfg
  import prog_lut_pkg::*;
#(
  parameter int TBL = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cfg_start,
  input  logic           i_cfg_valid,
  input  logic           i_cfg_data,
  output logic           o_commit,
  output logic [TBL-1:0] o_commit_data,
  output logic           o_busy
);

  localparam int CNT_W = cnt_bits(TBL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TBL - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TBL-1:0]   r_shadow;
  logic [TBL-1:0]   w_shadow_next;
  logic [TBL-1:0]   w_shifted;

  // LSB-first: the first bit received ends up at bit 0 after TBL shifts.
  assign w_shifted     = {i_cfg_data, r_shadow[TBL-1:1]};
  assign o_commit_data = w_shifted;
  assign o_busy        = (r_state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_shadow <= w_shadow_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_shadow_next = r_shadow;
    o_commit      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_cfg_start) begin
          w_state_next = ST_LOAD;
          w_cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        // The final bit wins over a simultaneous restart request.
        if (i_cfg_valid && (r_cnt == LAST)) begin
          o_commit      = 1'b1;
          w_shadow_next = w_shifted;
          w_cnt_next    = '0;
          w_state_next  = ST_RUN;
        end else if (i_cfg_start) begin
          w_cnt_next = '0;
        end else if (i_cfg_valid) begin
          w_shadow_next = w_shifted;
          w_cnt_next    = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

endmodule

// File: rtl/prog_lut.sv
// Runtime-programmable truth-table evaluator with atomic table swap and
// registered outputs; evaluation continues uninterrupted while a table loads.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int                         N_IN  = 4,
  parameter int                         N_OUT = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] INIT  = 16'h754B
) (
  input logic       clk,
  input logic       rst,
  prog_lut_if.slave bus
);

  localparam int NENT = 1 << N_IN;
  localparam int TBL  = tbl_bits(N_IN, N_OUT);

  logic [TBL-1:0]   r_active;
  logic [N_OUT-1:0] r_out_vec;
  logic             r_out_valid;
  logic             r_cfg_done;
  logic [N_OUT-1:0] w_eval;
  logic             w_commit;
  logic [TBL-1:0]   w_commit_data;
  logic             w_busy;

  prog_lut_cfg #(
    .TBL (TBL)
  ) u_cfg (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_start   (bus.cfg_start),
    .i_cfg_valid   (bus.cfg_valid),
    .i_cfg_data    (bus.cfg_data),
    .o_commit      (w_commit),
    .o_commit_data (w_commit_data),
    .o_busy        (w_busy)
  );

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_fn
    logic [NENT-1:0] w_fn;
    assign w_fn       = r_active[gi*NENT +: NENT];
    assign w_eval[gi] = w_fn[bus.in_vec];
  end

  // The lookup reads r_active before the commit lands, so the commit edge
  // still evaluates against the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= INIT;
      r_out_vec   <= '0;
      r_out_valid <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_cfg_done  <= w_commit;
      r_out_valid <= bus.in_valid;
      if (w_commit) begin
        r_active <= w_commit_data;
      end
      if (bus.in_valid) begin
        r_out_vec <= w_eval;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_out_vec;
  assign bus.cfg_done  = r_cfg_done;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_prog_lut.sv
// Self-checking bench for prog_lut: a 4-in/1-out and a 3-in/2-out instance
// checked against a plain table-lookup model.
module tb_prog_lut;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [15:0] mdl_a;
  logic [15:0] mdl_b;

  prog_lut_if #(.N_IN(4), .N_OUT(1)) ifa ();
  prog_lut_if #(.N_IN(3), .N_OUT(2)) ifb ();

  prog_lut #(.N_IN(4), .N_OUT(1), .INIT(16'h754B)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  prog_lut #(.N_IN(3), .N_OUT(2), .INIT(16'h754B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    ifa.in_valid = 0; ifa.in_vec = '0; ifa.cfg_start = 0; ifa.cfg_valid = 0; ifa.cfg_data = 0;
    ifb.in_valid = 0; ifb.in_vec = '0; ifb.cfg_start = 0; ifb.cfg_valid = 0; ifb.cfg_data = 0;
  endtask

  task automatic test_reset;
    logic [15:0] sweep;
    logic [1:0]  exp2;
    sweep = 16'b0111_0101_0100_1011; // in_vec 15..0 -> 0,1,1,1,0,1,0,1,0,1,0,0,1,0,1,1
    rst = 1; idle_inputs(); tick(); tick();
    checks++; if ({ifa.out_valid, ifa.out_vec, ifa.cfg_done, ifa.busy} !== 4'b0) begin
      failures++; $display("FAIL reset_a: got %b want 0000", {ifa.out_valid, ifa.out_vec, ifa.cfg_done, ifa.busy}); end
    checks++; if ({ifb.out_valid, ifb.out_vec, ifb.cfg_done, ifb.busy} !== 5'b0) begin
      failures++; $display("FAIL reset_b: got %b want 00000", {ifb.out_valid, ifb.out_vec, ifb.cfg_done, ifb.busy}); end
    rst = 0;
    mdl_a = 16'h754B; mdl_b = 16'h754B;
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1; ifa.in_vec = 4'(i); tick();
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_vec !== sweep[i]) begin
        failures++; $display("FAIL reset_sweep_a[%0d]: got v=%b o=%b want v=1 o=%b", i, ifa.out_valid, ifa.out_vec, sweep[i]); end
      $display("sweep_a in=%0d out=%b", i, ifa.out_vec);
    end
    ifa.in_vec = 4'd13; tick();
    ifa.in_valid = 0; tick();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out_vec !== 1'b1) begin
      failures++; $display("FAIL hold_a: got v=%b o=%b want v=0 o=1", ifa.out_valid, ifa.out_vec); end
    for (int i = 0; i < 8; i++) begin
      ifb.in_valid = 1; ifb.in_vec = 3'(i); tick();
      exp2 = {mdl_b[8+i], mdl_b[i]};
      checks++; if (ifb.out_valid !== 1'b1 || ifb.out_vec !== exp2) begin
        failures++; $display("FAIL reset_sweep_b[%0d]: got %b want %b", i, ifb.out_vec, exp2); end
      $display("sweep_b in=%0d out=%b", i, ifb.out_vec);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_load_contig;
    logic [15:0] tbl;
    tbl = 16'h8000;
    ifa.cfg_start = 1; tick(); ifa.cfg_start = 0;
    checks++; if (ifa.busy !== 1'b1) begin
      failures++; $display("FAIL contig_busy: got %b want 1", ifa.busy); end
    for (int b = 0; b < 16; b++) begin
      ifa.cfg_valid = 1; ifa.cfg_data = tbl[b]; tick();
      checks++; if (ifa.cfg_done !== (b == 15) || ifa.busy !== (b != 15)) begin
        failures++; $display("FAIL contig_bit[%0d]: got done=%b busy=%b want done=%b busy=%b",
                             b, ifa.cfg_done, ifa.busy, b == 15, b != 15); end
    end
    $display("load_contig tbl=%h done=%b", tbl, ifa.cfg_done);
    ifa.cfg_valid = 0; mdl_a = tbl;
    ifa.in_valid = 1; ifa.in_vec = 4'd15; tick();
    checks++; if (ifa.cfg_done !== 1'b0 || ifa.out_vec !== 1'b1) begin
      failures++; $display("FAIL contig_in15: got done=%b o=%b want done=0 o=1", ifa.cfg_done, ifa.out_vec); end
    ifa.in_vec = 4'd14; tick();
    checks++; if (ifa.out_vec !== 1'b0) begin
      failures++; $display("FAIL contig_in14: got %b want 0", ifa.out_vec); end
    idle_inputs(); tick();
  endtask

  task automatic test_eval_during_load(input int rounds);
    logic [15:0] tbl;
    logic [3:0]  vec;
    logic        v;
    logic        commit;
    int          sent;
    for (int r = 0; r < rounds; r++) begin
      tbl = 16'($urandom);
      ifa.cfg_start = 1; ifa.in_valid = 1; vec = 4'($urandom); ifa.in_vec = vec; tick();
      ifa.cfg_start = 0;
      checks++; if (ifa.out_vec !== mdl_a[vec]) begin
        failures++; $display("FAIL gap_start: got %b want %b", ifa.out_vec, mdl_a[vec]); end
      sent = 0;
      for (int cyc = 0; cyc < 400 && sent < 16; cyc++) begin
        vec = 4'($urandom); v = ($urandom % 3) != 0;
        ifa.in_vec = vec; ifa.cfg_valid = v; ifa.cfg_data = tbl[sent];
        commit = v && (sent == 15);
        tick();
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_vec !== mdl_a[vec]) begin
          failures++; $display("FAIL gap_eval r%0d c%0d: got %b want %b", r, cyc, ifa.out_vec, mdl_a[vec]); end
        checks++; if (ifa.cfg_done !== commit || ifa.busy !== !commit) begin
          failures++; $display("FAIL gap_ctrl r%0d c%0d: got done=%b busy=%b want done=%b busy=%b",
                               r, cyc, ifa.cfg_done, ifa.busy, commit, !commit); end
        if (v) sent++;
        if (commit) mdl_a = tbl;
      end
      checks++; if (sent != 16) begin
        failures++; $display("FAIL gap_timeout: got %0d bits want 16", sent); end
      ifa.cfg_valid = 0; vec = 4'($urandom); ifa.in_vec = vec; tick();
      checks++; if (ifa.out_vec !== mdl_a[vec] || ifa.cfg_done !== 1'b0) begin
        failures++; $display("FAIL gap_after: got o=%b done=%b want o=%b done=0", ifa.out_vec, ifa.cfg_done, mdl_a[vec]); end
      $display("eval_during_load round=%0d tbl=%h", r, tbl);
      idle_inputs(); tick();
    end
  endtask

  task automatic test_restart;
    logic [15:0] tbl;
    tbl = 16'h0001;
    ifa.cfg_start = 1; tick(); ifa.cfg_start = 0;
    for (int b = 0; b < 7; b++) begin
      ifa.cfg_valid = 1; ifa.cfg_data = 1'($urandom); tick();
    end
    ifa.cfg_valid = 0; ifa.cfg_start = 1; tick(); ifa.cfg_start = 0;
    for (int b = 0; b < 16; b++) begin
      ifa.cfg_valid = 1; ifa.cfg_data = tbl[b]; tick();
      checks++; if (ifa.cfg_done !== (b == 15) || ifa.busy !== (b != 15)) begin
        failures++; $display("FAIL restart_bit[%0d]: got done=%b busy=%b want done=%b busy=%b",
                             b, ifa.cfg_done, ifa.busy, b == 15, b != 15); end
    end
    ifa.cfg_valid = 0; mdl_a = tbl;
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1; ifa.in_vec = 4'(i); tick();
      checks++; if (ifa.out_vec !== mdl_a[i]) begin
        failures++; $display("FAIL restart_eval[%0d]: got %b want %b", i, ifa.out_vec, mdl_a[i]); end
    end
    $display("restart tbl=%h", tbl);
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid_load;
    ifa.cfg_start = 1; tick(); ifa.cfg_start = 0;
    for (int b = 0; b < 10; b++) begin
      ifa.cfg_valid = 1; ifa.cfg_data = 1'($urandom); tick();
    end
    idle_inputs(); rst = 1; tick(); rst = 0;
    checks++; if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.cfg_done !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl: got busy=%b ov=%b done=%b want 000", ifa.busy, ifa.out_valid, ifa.cfg_done); end
    mdl_a = 16'h754B; mdl_b = 16'h754B;
    // Further bits must not resume the abandoned load.
    for (int b = 0; b < 6; b++) begin
      ifa.cfg_valid = 1; ifa.cfg_data = 1'b1; tick();
      checks++; if (ifa.busy !== 1'b0 || ifa.cfg_done !== 1'b0) begin
        failures++; $display("FAIL midrst_ignore[%0d]: got busy=%b done=%b want 00", b, ifa.busy, ifa.cfg_done); end
    end
    ifa.cfg_valid = 0;
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1; ifa.in_vec = 4'(i); tick();
      checks++; if (ifa.out_vec !== mdl_a[i]) begin
        failures++; $display("FAIL midrst_eval[%0d]: got %b want %b", i, ifa.out_vec, mdl_a[i]); end
    end
    $display("reset_mid_load table restored");
    idle_inputs(); tick();
  endtask

  task automatic test_multi;
    logic [15:0] tbl;
    logic [1:0]  exp2;
    logic [2:0]  vec;
    tbl = 16'hF00F;
    ifb.cfg_start = 1; tick(); ifb.cfg_start = 0;
    for (int b = 0; b < 16; b++) begin
      ifb.cfg_valid = 1; ifb.cfg_data = tbl[b]; tick();
    end
    ifb.cfg_valid = 0;
    checks++; if (ifb.cfg_done !== 1'b1) begin
      failures++; $display("FAIL multi_done: got %b want 1", ifb.cfg_done); end
    mdl_b = tbl;
    ifb.in_valid = 1; ifb.in_vec = 3'd0; tick();
    checks++; if (ifb.out_vec !== 2'b01) begin
      failures++; $display("FAIL multi_in0: got %b want 01", ifb.out_vec); end
    ifb.in_vec = 3'd4; tick();
    checks++; if (ifb.out_vec !== 2'b10) begin
      failures++; $display("FAIL multi_in4: got %b want 10", ifb.out_vec); end
    for (int n = 0; n < 12; n++) begin
      vec = 3'($urandom); ifb.in_vec = vec; tick();
      exp2 = {mdl_b[8+vec], mdl_b[vec]};
      checks++; if (ifb.out_vec !== exp2) begin
        failures++; $display("FAIL multi_rand in=%0d: got %b want %b", vec, ifb.out_vec, exp2); end
    end
    $display("multi tbl=%h in0=01 in4=10 checked", tbl);
    idle_inputs(); tick();
  endtask

  task automatic test_back_to_back;
    logic [15:0] tbl;
    logic [3:0]  vec;
    for (int r = 0; r < 2; r++) begin
      tbl = 16'($urandom);
      ifa.cfg_start = 1; tick(); ifa.cfg_start = 0;
      for (int b = 0; b < 16; b++) begin
        ifa.cfg_valid = 1; ifa.cfg_data = tbl[b];
        ifa.cfg_start = (b == 15); // restart request colliding with the final bit
        tick();
      end
      idle_inputs();
      checks++; if (ifa.cfg_done !== 1'b1 || ifa.busy !== 1'b0) begin
        failures++; $display("FAIL b2b_commit r%0d: got done=%b busy=%b want done=1 busy=0", r, ifa.cfg_done, ifa.busy); end
      mdl_a = tbl;
      for (int n = 0; n < 8; n++) begin
        vec = 4'($urandom); ifa.in_valid = 1; ifa.in_vec = vec; tick();
        checks++; if (ifa.out_vec !== mdl_a[vec] || ifa.busy !== 1'b0) begin
          failures++; $display("FAIL b2b_eval r%0d in=%0d: got o=%b busy=%b want o=%b busy=0",
                               r, vec, ifa.out_vec, ifa.busy, mdl_a[vec]); end
      end
      $display("back_to_back round=%0d tbl=%h", r, tbl);
      idle_inputs();
    end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; idle_inputs();
    test_reset();
    test_load_contig();
    test_eval_during_load(3);
    test_restart();
    test_reset_mid_load();
    test_multi();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
